// File: rtl/result_drain_unit_pkg.sv
// Shared accelerator types for the result drain path.
// State encodings and index-width helpers.
package result_drain_unit_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b01,
      S_DRAIN = 2'b10
   } state_e;

   // Row/column index width: max(1, clog2(n)).
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Beat index width covering 0 .. n*n-1.
   function automatic int cnt_w(input int n);
      return $clog2(n * n);
   endfunction

endpackage

// File: rtl/result_drain_unit_if.sv
// Streaming result bus: valid/ready handshake
// carrying one element with its coordinates.
interface result_drain_unit_if #(
   parameter int N      = 4,
   parameter int DATA_W = 32
);
   import result_drain_unit_pkg::*;

   localparam int IDX_W = idx_w(N);

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_row;
   logic [IDX_W-1:0]  out_col;
   logic              out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_row,
      output out_col,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_row,
      input  out_col,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/result_drain_unit_result_buffer.sv
// Snapshot storage for one N x N result matrix:
// parallel load, single read port by beat index.
module result_buffer #(
   parameter int N      = 4,
   parameter int DATA_W = 32,
   parameter int K_W    = 4
) (
   input  logic                     clk,
   input  logic                     load_i,
   input  logic [N*N*DATA_W-1:0]    data_i,
   input  logic [K_W-1:0]           rd_idx_i,
   output logic [DATA_W-1:0]        rd_data_o
);

   localparam int NN = N * N;

   logic [DATA_W-1:0] mem_q [NN];

   // Capture the whole matrix in a single cycle.
   always_ff @(posedge clk) begin
      if (load_i) begin
         for (int i = 0; i < NN; i++) begin
            mem_q[i] <= data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/result_drain_unit.sv
// Snapshots the array accumulators on done and
// streams them out row-major over a valid/ready bus.
module result_drain_unit
   import result_drain_unit_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  done,
   input  logic [N*N*DATA_W-1:0] pe_results,
   result_drain_unit_if.master   out,
   output logic                  busy,
   output logic                  overrun
);

   localparam int NN    = N * N;
   localparam int K_W   = cnt_w(N);
   localparam int IDX_W = idx_w(N);

   localparam logic [K_W-1:0] K_LAST = K_W'(NN - 1);
   localparam logic [K_W-1:0] K_N    = K_W'(N);

   state_e         state_q, state_d;
   logic [K_W-1:0] k_q, k_d;
   logic           ovr_q, ovr_d;
   logic           load;
   logic           draining;
   logic           xfer;
   logic           last_xfer;

   assign draining  = (state_q == S_DRAIN);
   assign xfer      = draining && out.out_ready;
   assign last_xfer = xfer && (k_q == K_LAST);

   result_buffer #(
      .N      (N),
      .DATA_W (DATA_W),
      .K_W    (K_W)
   ) u_buf (
      .clk       (clk),
      .load_i    (load),
      .data_i    (pe_results),
      .rd_idx_i  (k_q),
      .rd_data_o (out.out_data)
   );

   // Next state: capture, advance, finish or flag a dropped done.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      ovr_d   = ovr_q;
      load    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (done) begin
               load    = 1'b1;
               k_d     = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (last_xfer) begin
               k_d = '0;
               if (done) begin
                  load = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               if (xfer) begin
                  k_d = k_q + 1'b1;
               end
               if (done) begin
                  ovr_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            k_d     = '0;
         end
      endcase
   end

   // State, beat index and sticky overrun registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out.out_valid = draining;
   assign out.out_last  = draining && (k_q == K_LAST);
   assign out.out_row   = IDX_W'(k_q / K_N);
   assign out.out_col   = IDX_W'(k_q % K_N);
   assign busy          = draining;
   assign overrun       = ovr_q;

endmodule

// File: doc/result_drain_unit.md
RESULT_DRAIN_UNIT -- requirements
Module: result_drain_unit

Interface
REQ-001 Parameter N, default 4, systolic array dimension (results matrix is N x N); legal range 2..16.
REQ-002 Parameter DATA_W, default 32, width of one PE accumulator result.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 done  input  1  one-cycle pulse from the array control unit; the results are valid in the same cycle.
REQ-006 pe_results  input  N*N*DATA_W  flattened accumulators; element (r,c) occupies bits [(r*N+c)*DATA_W +: DATA_W].
REQ-007 out_ready  input  1  downstream sink can accept a beat.
REQ-008 out_valid  output  1  out_data, out_row, out_col and out_last are valid.
REQ-009 out_data  output  DATA_W  result element being offered.
REQ-010 out_row  output  IDX_W  row index of the offered element; IDX_W = max(1, clog2(N)).
REQ-011 out_col  output  IDX_W  column index of the offered element.
REQ-012 out_last  output  1  the offered element is (N-1,N-1).
REQ-013 busy  output  1  a snapshot is held and not yet fully drained.
REQ-014 overrun  output  1  sticky; a done pulse was dropped.

Function
REQ-015 Two states SHALL exist: S_IDLE and S_DRAIN, encoded one-hot.
REQ-016 In S_IDLE with done=1, the block SHALL copy all N*N elements of pe_results into an internal snapshot buffer, clear the beat index to 0, and enter S_DRAIN at the next edge.
REQ-017 Latency SHALL be 1 cycle: done sampled at edge t gives out_valid=1 after edge t, with element (0,0) on out_data.
REQ-018 In S_DRAIN, out_valid SHALL be 1 and out_data SHALL equal the snapshot at beat index k, in row-major order (k = r*N + c).
REQ-019 A beat SHALL transfer only on an edge where out_valid=1 and out_ready=1; the index then increments by 1.
REQ-020 While out_ready=0, out_data, out_row, out_col and out_last SHALL hold stable, and out_valid SHALL stay 1.
REQ-021 out_last SHALL be 1 only when k = N*N-1.
REQ-022 On the transfer of the last beat, the block SHALL return to S_IDLE, and out_valid SHALL be 0 in the following cycle.
REQ-023 busy SHALL equal (state == S_DRAIN).
REQ-024 A done pulse in S_DRAIN SHALL be ignored: the snapshot and index are unchanged and overrun is set to 1.
REQ-025 A done pulse on the same edge as the last-beat transfer SHALL be accepted. The new snapshot is taken, the index resets to 0, the state stays S_DRAIN, and overrun is not set.
REQ-026 overrun SHALL stay 1 until reset.
REQ-027 pe_results SHALL be ignored in every cycle except a capture cycle.
REQ-028 The beat index SHALL be the sole counter; its width is clog2(N*N), with no wrap beyond N*N-1.

Reset
REQ-029 reset=1 at a clock edge SHALL force S_IDLE, index 0, out_valid=0, out_last=0, busy=0 and overrun=0.
REQ-030 Reset SHALL take priority over done and over an in-flight transfer; reset during S_DRAIN abandons the snapshot without emitting further beats.
REQ-031 The snapshot buffer contents need not be reset; out_data is don't-care while out_valid=0.

Structure
REQ-032 The state encodings (S_IDLE, S_DRAIN) and the IDX_W derivation SHALL live in the shared accelerator package.
REQ-033 The snapshot storage SHALL be a sub-module result_buffer: parallel load of N*N*DATA_W bits, read port indexed by k.

Verification
REQ-034 N=4, out_ready tied 1, done with element(r,c)=16*r+c: 16 beats on consecutive cycles, data 0,1,...,3,16,...,51; out_last only on beat 15 (data 51); busy falls after beat 15.
REQ-035 Backpressure: out_ready toggling 1,0,0,1,... during drain: all 16 values arrive in order, no duplicates, and outputs are stable while out_ready=0.
REQ-036 Overrun: second done at beat 5: the stream continues with the first snapshot, overrun=1 after that edge, and overrun stays 1 through subsequent idle cycles.
REQ-037 Back-to-back: second done on the same edge as beat 15 transfers: the next cycle shows out_valid=1 with new element (0,0), and overrun=0.
REQ-038 Reset at beat 7: the next cycle shows out_valid=0, busy=0, overrun=0; a later done restarts cleanly at (0,0).
REQ-039 N=2, DATA_W=8: 4 beats, with out_row/out_col sequence (0,0),(0,1),(1,0),(1,1) and out_last on beat 3.
